// File: rtl/generic_fifo_rd_ctrl.sv
// generic_fifo_rd_ctrl
// Read-side drain controller for the generic FIFO. Issues fifo_re only when
// the FIFO is non-empty and the 2-entry skid buffer can absorb the word
// returning one cycle later. Output is a valid/ready stream. In burst mode the
// controller waits for the FIFO almost-empty flag to drop, then drains exactly
// BL words and tags the final one with out_last.

module generic_fifo_rd_ctrl #(
  parameter int dw  = 8,
  parameter int BL  = 16,
  parameter int BLW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          burst_mode,
  output logic          fifo_re,
  input  logic [dw-1:0] fifo_dout,
  input  logic          fifo_empty,
  input  logic          fifo_empty_n,
  output logic [dw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  localparam logic [BLW-1:0] BL_C    = BLW'(BL);
  localparam logic [BLW-1:0] REM_ONE = {{(BLW-1){1'b0}}, 1'b1};
  localparam logic [BLW-1:0] REM_ZERO = {BLW{1'b0}};

  state_t         state_r;
  state_t         state_nxt_s;
  logic [BLW-1:0] rem_r;
  logic [BLW-1:0] rem_nxt_s;

  // Skid buffer: two {last,data} entries with 1-bit pointers and a fill count.
  logic [dw:0]    skid_r [0:1];
  logic           rd_ptr_r;
  logic           wr_ptr_r;
  logic [1:0]     cnt_r;

  // A read was issued last cycle; its word is on fifo_dout this cycle.
  logic           inflight_r;
  logic           inflight_last_r;

  logic           pop_s;
  logic           push_s;
  logic           gate_s;
  logic           re_s;
  logic           last_tag_s;
  logic [1:0]     occ_s;

  // Read legality: FIFO has data, skid can take the returning word, FSM allows it.
  always_comb begin
    pop_s  = (cnt_r != 2'd0) & out_ready;
    push_s = inflight_r;
    occ_s  = cnt_r + {1'b0, inflight_r};
    case (state_r)
      ST_IDLE:   gate_s = 1'b0;
      ST_STREAM: gate_s = 1'b1;
      ST_BURST:  gate_s = (rem_r != REM_ZERO);
      default:   gate_s = 1'b0;
    endcase
    re_s       = ~fifo_empty & ((occ_s < 2'd2) | pop_s) & gate_s & ~clr & ~rst;
    last_tag_s = (state_r == ST_BURST) & (rem_r == REM_ONE);
  end

  // Next-state and burst-remaining computation.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        if (!burst_mode) begin
          state_nxt_s = ST_STREAM;
        end else if (!fifo_empty_n) begin
          state_nxt_s = ST_BURST;
          rem_nxt_s   = BL_C;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (burst_mode) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_BURST: begin
        if (re_s) begin
          rem_nxt_s = rem_r - REM_ONE;
          if (rem_r == REM_ONE) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else begin
          state_nxt_s = ST_BURST;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        rem_nxt_s   = REM_ZERO;
      end
    endcase
  end

  // FSM state and burst counter registers; rst and clr both return to IDLE.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_r <= ST_IDLE;
      rem_r   <= REM_ZERO;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

  // In-flight tracking and skid control; a word in flight during clr is dropped.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      rd_ptr_r        <= 1'b0;
      wr_ptr_r        <= 1'b0;
      cnt_r           <= 2'd0;
    end else begin
      inflight_r      <= re_s;
      inflight_last_r <= last_tag_s;
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Skid storage; contents need no reset because cnt_r qualifies them.
  always_ff @(posedge clk) begin
    if (push_s && !rst && !clr) begin
      skid_r[wr_ptr_r] <= {inflight_last_r, fifo_dout};
    end else begin
      skid_r[wr_ptr_r] <= skid_r[wr_ptr_r];
    end
  end

  assign fifo_re   = re_s;
  assign out_data  = skid_r[rd_ptr_r][dw-1:0];
  assign out_valid = (cnt_r != 2'd0);
  assign out_last  = (cnt_r != 2'd0) & skid_r[rd_ptr_r][dw];
  assign busy      = (state_r != ST_IDLE) | (cnt_r != 2'd0) | inflight_r;

endmodule
